// File: rtl/fireball_pkg.sv
// Shared definitions for the fireball projectile controller and the
// OLED frame helpers (circle renderer, pixel-index-to-XY conversion).
package fireball_pkg;

  // Default frame geometry of the 96x64 OLED.
  localparam int FB_SCREEN_W = 96;
  localparam int FB_SCREEN_H = 64;

  // Projectile life cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    BURST    = 2'd2,
    COOLDOWN = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fireball_ctrl.sv
// Fireball motion / animation controller. Launches a circular projectile,
// moves it horizontally once per frame tick, grows a burst on hit, then
// holds a cooldown before the next launch. Drives the circle renderer's
// center and radius; radius 0 means nothing is drawn.
module fireball_ctrl
  import fireball_pkg::*;
#(
  parameter int SCREEN_W        = FB_SCREEN_W,
  parameter int SCREEN_H        = FB_SCREEN_H,
  parameter int SPEED           = 2,
  parameter int FLY_R           = 3,
  parameter int BURST_R         = 8,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        launch,
  input  logic [7:0]  launch_x,
  input  logic [7:0]  launch_y,
  input  logic        dir,
  input  logic        hit,
  output logic [7:0]  center_x,
  output logic [7:0]  center_y,
  output logic [15:0] radius,
  output logic        active,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [7:0]    X_MAX    = 8'(SCREEN_W - 1);
  localparam logic [7:0]    Y_MAX    = 8'(SCREEN_H - 1);
  localparam logic [8:0]    X_LIM9   = 9'(SCREEN_W - 1);
  localparam logic [8:0]    SPEED9   = 9'(SPEED);
  localparam logic [7:0]    SPEED8   = 8'(SPEED);
  localparam logic [7:0]    FLY_R8   = 8'(FLY_R);
  localparam logic [7:0]    BURST_R8 = 8'(BURST_R);
  localparam logic [CW-1:0] CD_LAST  = CW'(COOLDOWN_FRAMES - 1);

  // Saturate a launch coordinate to the last visible pixel.
  function automatic logic [7:0] clamp_coord(input logic [7:0] v,
                                             input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  fb_state_e     state_q, state_d;
  logic [7:0]    cx_q, cx_d;
  logic [7:0]    cy_q, cy_d;
  logic [7:0]    r_q, r_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic edge_right;
  logic edge_left;
  logic at_edge;

  // Edge test at 9 bits so center_x + SPEED cannot wrap.
  assign edge_right = ({1'b0, cx_q} + SPEED9) > X_LIM9;
  assign edge_left  = {1'b0, cx_q} < SPEED9;
  assign at_edge    = dir_q ? edge_left : edge_right;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; hit in FLY takes priority over an edge exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (launch) state_d = FLY;
      FLY: begin
        if (hit)                       state_d = BURST;
        else if (frame_tick && at_edge) state_d = COOLDOWN;
      end
      BURST:    if (frame_tick && (r_q == BURST_R8)) state_d = COOLDOWN;
      COOLDOWN: if (frame_tick && (cnt_q == CD_LAST)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of position, radius, cooldown counter and status outputs.
  always_comb begin
    cx_d     = cx_q;
    cy_d     = cy_q;
    r_d      = r_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    done_d   = (state_d == COOLDOWN) && (state_q != COOLDOWN);
    active_d = (state_d == FLY) || (state_d == BURST);
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (launch) begin
          cx_d  = clamp_coord(launch_x, X_MAX);
          cy_d  = clamp_coord(launch_y, Y_MAX);
          r_d   = FLY_R8;
          dir_d = dir;
        end
      end
      FLY: begin
        if (!hit && frame_tick) begin
          if (at_edge)    r_d  = 8'd0;
          else if (dir_q) cx_d = cx_q - SPEED8;
          else            cx_d = cx_q + SPEED8;
        end
      end
      BURST: begin
        if (frame_tick) begin
          if (r_q == BURST_R8) r_d = 8'd0;
          else                 r_d = r_q + 8'd1;
        end
      end
      COOLDOWN: begin
        r_d = 8'd0;
        if (frame_tick) cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
    if (done_d) cnt_d = '0;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q     <= 8'd0;
      cy_q     <= 8'd0;
      r_q      <= 8'd0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      r_q      <= r_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign center_x = cx_q;
  assign center_y = cy_q;
  assign radius   = {8'd0, r_q};
  assign active   = active_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/fireball_ctrl.md
# fireball_ctrl

Sequential motion and animation controller for a single circular projectile (fireball) on the 96x64 OLED frame. It accepts a launch request from the fighter logic and advances the projectile once per frame tick. On a hit it animates a growing burst, then holds a cooldown before the next launch is accepted. It sits directly upstream of the circle renderer and drives that renderer's center_X, center_Y and radius inputs; radius 0 means nothing is drawn.

## Interface
Parameters:
- SCREEN_W, 96: frame width in pixels.
- SCREEN_H, 64: frame height in pixels.
- SPEED, 2: horizontal pixels moved per frame tick in FLY.
- FLY_R, 3: radius while flying.
- BURST_R, 8: final burst radius; must be greater than FLY_R.
- COOLDOWN_FRAMES, 30: frame ticks spent in COOLDOWN; must be at least 1.

Ports:
- clk, in, 1: system clock. One clock domain.
- rst_n, in, 1: reset. Asynchronous, active-low.
- frame_tick, in, 1: one-cycle pulse, once per display frame.
- launch, in, 1: launch request, sampled every cycle.
- launch_x, in, 8: start X.
- launch_y, in, 8: start Y.
- dir, in, 1: 0 = move right (+X), 1 = move left (-X).
- hit, in, 1: collision with the opponent hitbox.
- center_x, out, 8: to circle renderer center_X.
- center_y, out, 8: to circle renderer center_Y.
- radius, out, 16: to circle renderer radius. 0 when not visible.
- active, out, 1: projectile visible (FLY or BURST).
- busy, out, 1: state is not IDLE.
- done, out, 1: one-cycle pulse on entry to COOLDOWN.

## Operation
- States: IDLE, FLY, BURST, COOLDOWN. All outputs are registered.
- Reset values: state IDLE; center_x, center_y, radius, active, busy and done all 0. Reset asserted mid-operation forces these values immediately; the pending cooldown is discarded.
- IDLE:
  - launch=1 moves the block to FLY.
  - center_x is loaded with launch_x clamped to SCREEN_W-1.
  - center_y is loaded with launch_y clamped to SCREEN_H-1.
  - radius is set to FLY_R; the dir value is latched.
  - hit is ignored.
- FLY:
  - hit=1 on any cycle (tick or not) moves to BURST. Center freezes, radius is kept.
  - On frame_tick with no hit, the block checks the next position:
    - Right: if center_x+SPEED > SCREEN_W-1, go to COOLDOWN.
    - Left: if center_x < SPEED, go to COOLDOWN.
    - Otherwise center_x moves by SPEED.
  - Edge exit sets radius 0 and active 0.
  - hit and edge on the same tick: hit wins.
- BURST:
  - On each frame_tick: if radius == BURST_R, go to COOLDOWN with radius 0. Otherwise radius increments by 1.
  - Center stays fixed; further hits are ignored.
- COOLDOWN:
  - active=0 and radius=0.
  - The counter clears on entry and increments on each frame_tick.
  - The tick on which the counter reaches COOLDOWN_FRAMES moves the block to IDLE.
- done pulses high for exactly one cycle on the transition into COOLDOWN, from either the edge or the burst path.
- launch outside IDLE is dropped. It is not queued.
- active=1 exactly in FLY and BURST. busy=1 in every state except IDLE.
- Arithmetic:
  - Edge compare is done at 9 bits so center_x+SPEED cannot wrap.
  - The radius upper 8 bits are always 0.
  - The cooldown counter is $clog2(COOLDOWN_FRAMES+1) bits.

## Timing
- Launch latency: launch at edge n; center, radius and active are valid after edge n+1.
- Motion: position updates are visible the cycle after the frame_tick edge.
- Hit latency: one cycle from hit to state BURST. Radius first grows on the next frame_tick.
- Burst duration: BURST_R-FLY_R growth ticks, plus one tick to exit.
- Outputs are stable between ticks, so the renderer sees one consistent circle per frame.

## Structure
- Shared package fireball_pkg holds:
  - the state enum (IDLE, FLY, BURST, COOLDOWN);
  - SCREEN_W/SCREEN_H defaults, shared with the renderer and the pixel-index-to-XY conversion.
- No sub-module: one FSM process plus the position, radius and cooldown registers. Target is about 150-250 lines.

## Test plan
- Reset and idle:
  - Assert rst_n=0 mid-FLY (x=40): center_x, center_y, radius, active, busy and done are all 0 immediately.
  - After release, launch=0 for 5 ticks: all outputs stay 0.
- Launch and fly right:
  - Launch at (10,40) with dir=0.
  - Next cycle: center (10,40), radius 3, active=1.
  - After 3 ticks: center_x=16.
  - A second launch at (50,10) during flight is ignored.
- Right-edge exit:
  - Launch at x=90: ticks give x=92, then x=94.
  - Third tick: COOLDOWN, radius 0, active 0, done pulses for 1 cycle.
  - After 30 more ticks: busy=0.
- Left-edge exit:
  - Launch at x=5, dir=1: x=3, then x=1.
  - Next tick: COOLDOWN, done pulse.
  - Launch with launch_x=200 loads center_x=95.
- Hit and burst:
  - Hit at x=20: center freezes at 20.
  - Radius over ticks: 4, 5, 6, 7, 8.
  - Sixth tick: radius 0, done pulse.
  - hit asserted on the same tick as an edge crossing: BURST is taken, not an edge exit.
- Cooldown gating:
  - launch held high through COOLDOWN is dropped.
  - Accepted on the first cycle in IDLE: center loads on the following cycle.
  - Reset during BURST (radius 6): outputs go to 0 and state is IDLE.
